// File: rtl/four_way_tdm_pkg.sv
// Shared definitions for the four-way TDM bus (transmit and receive sides).
package four_way_tdm_pkg;

  typedef logic [1:0] slot_t;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam slot_t LAST_SLOT = 2'd3;

  // Slot that follows k in a frame; slot 3 wraps back to slot 0.
  function automatic slot_t next_slot(input slot_t k);
    return slot_t'(k + 2'd1);
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot position counter for the TDM receiver.
// load0 : the current beat is a slot-0 beat (frame_sync), so the next beat is slot 1.
// adv   : the current beat was accepted at slot s, so move on to the next slot.
// wrap  : the current beat is the last slot of a frame (combinational, same cycle as adv).
module tdm_slot_counter
  import four_way_tdm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       adv,
  input  logic       load0,
  output logic [1:0] s,
  output logic       wrap
);

  slot_t s_q;
  slot_t s_d;

  // Next slot: a sync beat restarts the count, otherwise step on accepted beats.
  always_comb begin
    s_d = s_q;
    if (load0) begin
      s_d = next_slot(2'd0);
    end else if (adv) begin
      s_d = next_slot(s_q);
    end
  end

  // Slot register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q <= 2'd0;
    end else begin
      s_q <= s_d;
    end
  end

  assign s    = s_q;
  assign wrap = adv && !load0 && (s_q == LAST_SLOT);

endmodule

// File: rtl/four_way_tdm_demux.sv
// Receive side of the four-way TDM bus: aligns to frame_sync, de-interleaves
// beats into shadow registers and publishes each complete frame atomically.
module four_way_tdm_demux
  import four_way_tdm_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             bus_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] d0,
  output logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] d3,
  output logic [1:0]       s,
  output logic             locked,
  output logic             frame_valid,
  output logic             sync_err,
  output logic [CNT_W-1:0] frame_cnt
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shadow_q [0:2];
  logic [WIDTH-1:0] shadow_d [0:2];
  logic [WIDTH-1:0] d_q      [0:3];
  logic [WIDTH-1:0] d_d      [0:3];
  logic             frame_valid_q, frame_valid_d;
  logic             sync_err_q, sync_err_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic             sync_beat;
  logic             adv;
  logic             wrap;
  logic [1:0]       slot;

  // A sync beat always restarts the frame; plain beats only count once locked.
  // Neither is asserted while bus_valid=0, so bus_in is never sampled then.
  assign sync_beat = bus_valid && frame_sync;
  assign adv       = bus_valid && !frame_sync && (state_q == LOCKED);

  tdm_slot_counter u_slot_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (adv),
    .load0 (sync_beat),
    .s     (slot),
    .wrap  (wrap)
  );

  // Next-state, shadow capture, frame publish and error/valid pulses.
  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    d_d           = d_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    frame_cnt_d   = frame_cnt_q;

    if (sync_beat) begin
      // A sync beat in the middle of a frame drops the partial frame.
      sync_err_d  = (state_q == LOCKED) && (slot != 2'd0);
      shadow_d[0] = bus_in;
      state_d     = LOCKED;
    end else if (wrap) begin
      d_d[0]        = shadow_q[0];
      d_d[1]        = shadow_q[1];
      d_d[2]        = shadow_q[2];
      d_d[3]        = bus_in;
      frame_valid_d = 1'b1;
      frame_cnt_d   = frame_cnt_q + 1'b1;
    end else if (adv) begin
      case (slot)
        2'd0:    shadow_d[0] = bus_in;
        2'd1:    shadow_d[1] = bus_in;
        2'd2:    shadow_d[2] = bus_in;
        default: ;
      endcase
    end
  end

  // FSM and all datapath registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      shadow_q      <= '{default: '0};
      d_q           <= '{default: '0};
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      d_q           <= d_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign d0          = d_q[0];
  assign d1          = d_q[1];
  assign d2          = d_q[2];
  assign d3          = d_q[3];
  assign s           = slot;
  assign locked      = (state_q == LOCKED);
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_four_way_tdm_demux.sv
// Bench for four_way_tdm_demux: directed vector table, frame-counter wrap
// sequence, and random traffic against a queue-based frame model.
`timescale 1ns/1ps
module tb_four_way_tdm_demux;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] bus_in;
  logic             bus_valid;
  logic             frame_sync;
  logic [WIDTH-1:0] d0, d1, d2, d3;
  logic [1:0]       s;
  logic             locked;
  logic             frame_valid;
  logic             sync_err;
  logic [CNT_W-1:0] frame_cnt;

  int n_vec = 0;
  int n_mis = 0;

  four_way_tdm_demux #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus_in      (bus_in),
    .bus_valid   (bus_valid),
    .frame_sync  (frame_sync),
    .d0          (d0),
    .d1          (d1),
    .d2          (d2),
    .d3          (d3),
    .s           (s),
    .locked      (locked),
    .frame_valid (frame_valid),
    .sync_err    (sync_err),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: beats collected since the last frame start.
  logic [7:0]  m_part[$];
  bit          m_locked;
  logic [31:0] m_d;
  int          m_cnt;
  bit          m_fv;
  bit          m_err;

  task automatic model_step(input logic r, input logic v, input logic fs, input logic [7:0] data);
    m_fv  = 1'b0;
    m_err = 1'b0;
    if (!r) begin
      m_part.delete();
      m_locked = 1'b0;
      m_d      = '0;
      m_cnt    = 0;
    end else if (v) begin
      if (fs) begin
        if (m_locked && m_part.size() != 0) m_err = 1'b1;
        m_part.delete();
        m_part.push_back(data);
        m_locked = 1'b1;
      end else if (m_locked) begin
        m_part.push_back(data);
        if (m_part.size() == 4) begin
          m_d   = {m_part[0], m_part[1], m_part[2], m_part[3]};
          m_fv  = 1'b1;
          m_cnt = (m_cnt + 1) % (1 << CNT_W);
          m_part.delete();
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, sample 1ns later.
  task automatic cycle(input logic r, input logic v, input logic fs, input logic [7:0] data);
    @(negedge clk);
    rst_n      = r;
    bus_valid  = v;
    frame_sync = fs;
    bus_in     = data;
    @(posedge clk);
    #1;
    model_step(r, v, fs, data);
  endtask

  typedef struct {
    logic        r;
    logic        v;
    logic        fs;
    logic [7:0]  data;
    logic [1:0]  e_s;
    logic        e_lk;
    logic        e_fv;
    logic        e_err;
    logic [31:0] e_d;
    logic [3:0]  e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic v, input logic fs, input logic [7:0] data,
                              input logic [1:0] e_s, input logic e_lk, input logic e_fv,
                              input logic e_err, input logic [31:0] e_d, input logic [3:0] e_cnt);
    vec_t t;
    t.r = r; t.v = v; t.fs = fs; t.data = data;
    t.e_s = e_s; t.e_lk = e_lk; t.e_fv = e_fv; t.e_err = e_err; t.e_d = e_d; t.e_cnt = e_cnt;
    return t;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [7:0] zz;
    logic [7:0] xx;
    zz = 'z;
    xx = 'x;
    rst_n = 1'b0; bus_valid = 1'b0; frame_sync = 1'b0; bus_in = zz;

    //                r  v  fs data   s  lk fv er d             cnt
    tbl.push_back(mk(0, 0, 0, zz,    0, 0, 0, 0, 32'h0,        0));
    tbl.push_back(mk(1, 0, 0, zz,    0, 0, 0, 0, 32'h0,        0));
    tbl.push_back(mk(1, 1, 1, 8'hA0, 1, 1, 0, 0, 32'h0,        0));
    tbl.push_back(mk(1, 1, 0, 8'hA1, 2, 1, 0, 0, 32'h0,        0));
    tbl.push_back(mk(1, 1, 0, 8'hA2, 3, 1, 0, 0, 32'h0,        0));
    tbl.push_back(mk(1, 1, 0, 8'hA3, 0, 1, 1, 0, 32'hA0A1A2A3, 1));
    tbl.push_back(mk(1, 0, 0, zz,    0, 1, 0, 0, 32'hA0A1A2A3, 1));
    tbl.push_back(mk(0, 0, 0, zz,    0, 0, 0, 0, 32'h0,        0));
    tbl.push_back(mk(1, 1, 0, 8'h11, 0, 0, 0, 0, 32'h0,        0));
    tbl.push_back(mk(1, 1, 0, 8'h22, 0, 0, 0, 0, 32'h0,        0));
    tbl.push_back(mk(1, 1, 1, 8'h33, 1, 1, 0, 0, 32'h0,        0));
    tbl.push_back(mk(1, 1, 0, 8'h44, 2, 1, 0, 0, 32'h0,        0));
    tbl.push_back(mk(1, 1, 0, 8'h55, 3, 1, 0, 0, 32'h0,        0));
    tbl.push_back(mk(1, 1, 0, 8'h66, 0, 1, 1, 0, 32'h33445566, 1));
    tbl.push_back(mk(1, 1, 1, 8'hB0, 1, 1, 0, 0, 32'h33445566, 1));
    tbl.push_back(mk(1, 1, 0, 8'hB1, 2, 1, 0, 0, 32'h33445566, 1));
    tbl.push_back(mk(1, 1, 1, 8'hC0, 1, 1, 0, 1, 32'h33445566, 1));
    tbl.push_back(mk(1, 1, 0, 8'hC1, 2, 1, 0, 0, 32'h33445566, 1));
    tbl.push_back(mk(1, 1, 0, 8'hC2, 3, 1, 0, 0, 32'h33445566, 1));
    tbl.push_back(mk(1, 1, 0, 8'hC3, 0, 1, 1, 0, 32'hC0C1C2C3, 2));
    tbl.push_back(mk(1, 1, 1, 8'hD0, 1, 1, 0, 0, 32'hC0C1C2C3, 2));
    tbl.push_back(mk(1, 0, 0, xx,    1, 1, 0, 0, 32'hC0C1C2C3, 2));
    tbl.push_back(mk(1, 1, 0, 8'hD1, 2, 1, 0, 0, 32'hC0C1C2C3, 2));
    tbl.push_back(mk(1, 0, 1, xx,    2, 1, 0, 0, 32'hC0C1C2C3, 2));
    tbl.push_back(mk(1, 1, 0, 8'hD2, 3, 1, 0, 0, 32'hC0C1C2C3, 2));
    tbl.push_back(mk(1, 0, 0, xx,    3, 1, 0, 0, 32'hC0C1C2C3, 2));
    tbl.push_back(mk(1, 1, 0, 8'hD3, 0, 1, 1, 0, 32'hD0D1D2D3, 3));
    tbl.push_back(mk(1, 0, 0, xx,    0, 1, 0, 0, 32'hD0D1D2D3, 3));
    tbl.push_back(mk(1, 1, 1, 8'hE0, 1, 1, 0, 0, 32'hD0D1D2D3, 3));
    tbl.push_back(mk(1, 1, 0, 8'hE1, 2, 1, 0, 0, 32'hD0D1D2D3, 3));
    tbl.push_back(mk(1, 1, 0, 8'hE2, 3, 1, 0, 0, 32'hD0D1D2D3, 3));
    tbl.push_back(mk(0, 1, 1, 8'hE3, 0, 0, 0, 0, 32'h0,        0));
    tbl.push_back(mk(1, 0, 0, zz,    0, 0, 0, 0, 32'h0,        0));

    // Directed table.
    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].r, tbl[i].v, tbl[i].fs, tbl[i].data);
      chk($sformatf("tbl[%0d].s", i),           {30'd0, s},          {30'd0, tbl[i].e_s});
      chk($sformatf("tbl[%0d].locked", i),      {31'd0, locked},     {31'd0, tbl[i].e_lk});
      chk($sformatf("tbl[%0d].frame_valid", i), {31'd0, frame_valid},{31'd0, tbl[i].e_fv});
      chk($sformatf("tbl[%0d].sync_err", i),    {31'd0, sync_err},   {31'd0, tbl[i].e_err});
      chk($sformatf("tbl[%0d].d", i),           {d0, d1, d2, d3},    tbl[i].e_d);
      chk($sformatf("tbl[%0d].frame_cnt", i),   {28'd0, frame_cnt},  {28'd0, tbl[i].e_cnt});
    end

    // Counter wrap: 17 back-to-back frames from reset on the 4-bit counter.
    cycle(1'b0, 1'b0, 1'b0, zz);
    for (int f = 0; f < 17; f++) begin
      for (int b = 0; b < 4; b++) begin
        cycle(1'b1, 1'b1, (f == 0 && b == 0), 8'(f * 4 + b));
        chk($sformatf("wrap f%0d b%0d frame_valid", f, b), {31'd0, frame_valid}, {31'd0, (b == 3)});
      end
      chk($sformatf("wrap f%0d frame_cnt", f), {28'd0, frame_cnt}, 32'((f + 1) % 16));
      chk($sformatf("wrap f%0d d", f), {d0, d1, d2, d3},
          {8'(f * 4), 8'(f * 4 + 1), 8'(f * 4 + 2), 8'(f * 4 + 3)});
    end
    chk("wrap final frame_cnt", {28'd0, frame_cnt}, 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      logic r, v, fs;
      logic [7:0] data;
      r    = ($urandom_range(0, 99) != 0);
      v    = ($urandom_range(0, 3) != 0);
      fs   = ($urandom_range(0, 5) == 0);
      data = v ? 8'($urandom) : xx;
      cycle(r, v, fs, data);
      chk($sformatf("rnd[%0d].s", i),           {30'd0, s},           32'(m_part.size()));
      chk($sformatf("rnd[%0d].locked", i),      {31'd0, locked},      {31'd0, m_locked});
      chk($sformatf("rnd[%0d].frame_valid", i), {31'd0, frame_valid}, {31'd0, m_fv});
      chk($sformatf("rnd[%0d].sync_err", i),    {31'd0, sync_err},    {31'd0, m_err});
      chk($sformatf("rnd[%0d].d", i),           {d0, d1, d2, d3},     m_d);
      chk($sformatf("rnd[%0d].frame_cnt", i),   {28'd0, frame_cnt},   32'(m_cnt));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/four_way_tdm_demux.md
# four_way_tdm_demux

Receive side of the four-way multiplexed bus. The transmitter drives one of four lanes onto a shared tristate bus per beat, selected by a 2-bit slot index. This block samples that bus, tracks the slot position from a frame-sync marker, and de-interleaves beats back into four lane registers. It presents each completed 4-beat frame atomically, with a one-cycle valid pulse, to downstream logic.

## Interface
Parameters:
- WIDTH, 8, bit width of each lane and of the shared bus
- CNT_W, 16, width of the completed-frame counter

Ports:
- clk  input  1  single clock; all state changes on rising edge
- rst_n  input  1  reset, synchronous and active-low
- bus_in  input  WIDTH  shared bus data; may be Z/X when bus_valid=0
- bus_valid  input  1  bus_in holds a driven beat this cycle
- frame_sync  input  1  qualifies the current beat as slot 0; ignored when bus_valid=0
- d0, d1, d2, d3  output  WIDTH  de-interleaved lanes of the last complete frame
- s  output  2  slot index the next accepted beat will be written to
- locked  output  1  receiver aligned to frame boundaries
- frame_valid  output  1  one-cycle pulse; d0..d3 just updated with a new frame
- sync_err  output  1  one-cycle pulse; frame_sync seen mid-frame
- frame_cnt  output  CNT_W  completed frames since reset; wraps modulo 2^CNT_W

## Operation
- States: HUNT and LOCKED.
- Reset state: HUNT. On reset, all of these are 0: s, locked, d0..d3, frame_valid, sync_err, frame_cnt, and the shadow registers.
- HUNT:
  - A beat with frame_sync=1 is captured into shadow slot 0. Set s=1 and go to LOCKED.
  - Beats without frame_sync are dropped. s stays 0.
- LOCKED, accepted beat at s=k with frame_sync=0:
  - k<3: store into shadow[k]; s=k+1.
  - k=3: load d0..d3 ← {shadow0, shadow1, shadow2, bus_in}; pulse frame_valid; frame_cnt+1; s wraps to 0.
- LOCKED, beat with frame_sync=1:
  - s=0: normal slot-0 capture.
  - s≠0: pulse sync_err and discard the partial frame (shadows are not copied out). Treat this beat as slot 0: shadow0 ← bus_in, s=1, stay LOCKED.
- bus_valid=0: no state change. bus_in is never sampled, so Z/X on the bus must not propagate.
- d0..d3 change only on frame completion. They are never partially updated.
- locked = (state==LOCKED).
- frame_cnt wraps from all-ones to 0 with no flag.

## Timing
- One beat accepted per cycle maximum. There is no backpressure; the block must sustain bus_valid=1 every cycle.
- All outputs are registered.
- Latency: the slot-3 beat sampled at edge N → d0..d3 new, frame_valid=1, and frame_cnt incremented, all visible after edge N. frame_valid is low again after edge N+1 unless another frame completes.
- sync_err asserts after the edge that sampled the offending beat, for exactly one cycle.
- Back-to-back frames: frame_valid may pulse every 4th cycle with no gap.
- Reset mid-frame: rst_n=0 at any edge overrides all other inputs. The partial frame is lost and the block returns to HUNT.

## Structure
- Shared package four_way_tdm_pkg holds:
  - typedef slot_t (2-bit)
  - state enum {HUNT, LOCKED}
  - constant LAST_SLOT=2'd3
  - Both this block and the transmitter import it.
- Sub-module tdm_slot_counter owns the slot counter, with ports clk, rst_n, adv, load0, s, wrap.
- This block holds the FSM, the shadow and output registers, and frame_cnt.

## Test plan
- Reset, then idle with bus_valid=0 and bus_in=Z → all outputs 0, locked=0, no X on any output.
- Stream 8'hA0 (frame_sync=1), then A1, A2, A3 on consecutive cycles → after the 4th edge: d0..d3=A0,A1,A2,A3; frame_valid one cycle; frame_cnt=1; s=0.
- In HUNT, send beats 11, 22 without frame_sync, then 33 (sync), 44, 55, 66 → frame {33,44,55,66}; 11 and 22 dropped.
- While locked, send B0(sync), B1, C0(sync), C1, C2, C3 → sync_err pulses on C0; d0..d3 stay at the previous frame until the {C0,C1,C2,C3} frame completes.
- Insert bus_valid=0 gaps between every beat, with bus_in=X during the gaps → same frame result as gap-free; frame_valid held off until slot 3 arrives.
- Preload frame_cnt near wrap (CNT_W=4 build); complete 17 frames → frame_cnt=1. Assert rst_n=0 after slot 2 of a frame → next cycle s=0, locked=0, d0..d3=0.
